// File: rtl/countdown_timer_mmss_pkg.sv
// Shared state encoding, BCD constants and digit saturation for the mm:ss countdown timer.
package countdown_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [7:0] ZERO_BCD = 8'h00;
   localparam logic [7:0] WRAP_BCD = 8'h59;

   // Clamp each BCD digit to its legal maximum so a bad preset still counts sanely.
   function automatic logic [7:0] bcd_sat(input logic [7:0] v,
                                          input logic [3:0] tens_max,
                                          input logic [3:0] units_max);
      logic [3:0] t;
      logic [3:0] u;
      t = (v[7:4] > tens_max)  ? tens_max  : v[7:4];
      u = (v[3:0] > units_max) ? units_max : v[3:0];
      return {t, u};
   endfunction

endpackage

// File: rtl/countdown_timer_mmss_if.sv
// Control/status bundle of the countdown timer; master drives controls, slave is the timer.
interface countdown_timer_mmss_if;
   logic       tick;
   logic       load;
   logic       start;
   logic       pause;
   logic [7:0] preset_min;
   logic [7:0] preset_sec;
   logic [7:0] min_q;
   logic [7:0] sec_q;
   logic       sec_borrow;
   logic       running;
   logic       done;

   modport master (output tick, load, start, pause, preset_min, preset_sec,
                   input  min_q, sec_q, sec_borrow, running, done);
   modport slave  (input  tick, load, start, pause, preset_min, preset_sec,
                   output min_q, sec_q, sec_borrow, running, done);
endinterface

// File: rtl/countdown_timer_mmss_bcd60.sv
// Mod-60 BCD down counter: 00 wraps to {TENS_MAX,UNITS_MAX} and raises bo combinationally.
module bcd_down_counter60
   import countdown_pkg::*;
#(
   parameter int unsigned TENS_MAX  = 5,
   parameter int unsigned UNITS_MAX = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       ld,
   input  logic [7:0] d,
   output logic [7:0] q,
   output logic       bo
);

   localparam logic [3:0] TMAX = TENS_MAX[3:0];
   localparam logic [3:0] UMAX = UNITS_MAX[3:0];

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = d;
      end else if (en) begin
         if (cnt_q[3:0] == 4'd0) begin
            cnt_d[3:0] = UMAX;
            cnt_d[7:4] = (cnt_q[7:4] == 4'd0) ? TMAX : cnt_q[7:4] - 4'd1;
         end else begin
            cnt_d[3:0] = cnt_q[3:0] - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= ZERO_BCD;
      else     cnt_q <= cnt_d;
   end

   assign q  = cnt_q;
   assign bo = en && (cnt_q == ZERO_BCD);

endmodule

// File: rtl/countdown_timer_mmss.sv
// mm:ss BCD countdown timer with load/start/pause control and a done pulse at 00:00.
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN to reload on terminal count.
module countdown_timer_mmss
   import countdown_pkg::*;
#(
   parameter int unsigned TENS_MAX  = 5,
   parameter int unsigned UNITS_MAX = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   countdown_timer_mmss_if.slave bus
);

   logic [1:0]  state_q, state_d;
   logic [15:0] reload_q, reload_d;
   logic        sec_borrow_q, sec_borrow_d;
   logic        running_q, running_d;
   logic        done_q, done_d;

   logic [7:0]  sec_val, min_val;
   logic        sec_en, sec_bo, min_bo;
   logic        load_acc, count_zero, term, reload_hit, cnt_ld;
   logic [15:0] preset_sat, cnt_d;

   // tick is only honoured in RUN and loses to a coincident pause
   assign sec_en     = bus.tick && (state_q == ST_RUN) && !bus.pause;
   assign load_acc   = bus.load && (state_q != ST_RUN);
   assign count_zero = (min_val == ZERO_BCD) && (sec_val == ZERO_BCD);
   assign term       = sec_en && (min_val == ZERO_BCD) && (sec_val == 8'h01);
   assign preset_sat = {bcd_sat(bus.preset_min, TENS_MAX[3:0], UNITS_MAX[3:0]),
                        bcd_sat(bus.preset_sec, TENS_MAX[3:0], UNITS_MAX[3:0])};

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   assign reload_hit = term && (reload_q != 16'h0000);
`else
   assign reload_hit = 1'b0;
`endif

   assign cnt_ld = load_acc || reload_hit;
   assign cnt_d  = load_acc ? preset_sat : reload_q;

   bcd_down_counter60 #(.TENS_MAX(TENS_MAX), .UNITS_MAX(UNITS_MAX)) u_sec (
      .clk(clk), .rst(rst), .en(sec_en), .ld(cnt_ld), .d(cnt_d[7:0]),
      .q(sec_val), .bo(sec_bo)
   );

   bcd_down_counter60 #(.TENS_MAX(TENS_MAX), .UNITS_MAX(UNITS_MAX)) u_min (
      .clk(clk), .rst(rst), .en(sec_bo), .ld(cnt_ld), .d(cnt_d[15:8]),
      .q(min_val), .bo(min_bo)
   );

   always_comb begin
      state_d      = state_q;
      reload_d     = reload_q;
      sec_borrow_d = sec_bo;
      done_d       = term;
      if (load_acc) begin
         state_d  = ST_IDLE;
         reload_d = preset_sat;
      end else if (state_q == ST_RUN) begin
         if (bus.pause)             state_d = ST_PAUSE;
         else if (term)             state_d = reload_hit ? ST_RUN : ST_DONE;
         else if (min_bo)           state_d = ST_DONE;  // underflow guard, unreachable in normal run
      end else if ((state_q == ST_IDLE || state_q == ST_PAUSE) &&
                   bus.start && !bus.pause && !count_zero) begin
         state_d = ST_RUN;
      end
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         reload_q     <= 16'h0000;
         sec_borrow_q <= 1'b0;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         reload_q     <= reload_d;
         sec_borrow_q <= sec_borrow_d;
         running_q    <= running_d;
         done_q       <= done_d;
      end
   end

   assign bus.min_q      = min_val;
   assign bus.sec_q      = sec_val;
   assign bus.sec_borrow = sec_borrow_q;
   assign bus.running    = running_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Directed bench for countdown_timer_mmss; expected values are hand-computed per scenario.
module tb_countdown_timer_mmss;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   countdown_timer_mmss_if bus ();

   countdown_timer_mmss dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // snapshot: {min, sec, sec_borrow, running, done}
   function automatic logic [18:0] snap();
      return {bus.min_q, bus.sec_q, bus.sec_borrow, bus.running, bus.done};
   endfunction

   // one clock with the given pulses, outputs then sampled 1 ns after the edge
   task automatic cyc(input logic l, input logic s, input logic p, input logic t);
      bus.load = l; bus.start = s; bus.pause = p; bus.tick = t;
      @(posedge clk);
      #1;
      bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] m, input logic [7:0] s);
      bus.preset_min = m; bus.preset_sec = s;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      #3;
      total++;
      if (snap() !== 19'h0) $display("FAIL reset_state got %h want %h", snap(), 19'h0);
      else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_load(8'h00, 8'h30);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (snap() !== {8'h00, 8'h27, 3'b010}) $display("FAIL pre_reset got %h want %h", snap(), {8'h00, 8'h27, 3'b010});
      else passed++;
      rst = 1'b1;
      #2;
      total++;
      if (snap() !== 19'h0) $display("FAIL async_reset got %h want %h", snap(), 19'h0);
      else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (snap() !== 19'h0) $display("FAIL start_after_reset got %h want %h", snap(), 19'h0);
      else passed++;
   endtask

   task automatic test_borrow_and_done();
      int nb, nd;
      do_load(8'h02, 8'h00);
      total++;
      if (snap() !== {8'h02, 8'h00, 3'b000}) $display("FAIL load_0200 got %h want %h", snap(), {8'h02, 8'h00, 3'b000});
      else passed++;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (snap() !== {8'h01, 8'h59, 3'b110}) $display("FAIL tick_0200 got %h want %h", snap(), {8'h01, 8'h59, 3'b110});
      else passed++;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (snap() !== {8'h01, 8'h59, 3'b010}) $display("FAIL borrow_one_cycle got %h want %h", snap(), {8'h01, 8'h59, 3'b010});
      else passed++;
      nb = 0; nd = 0;
      for (int k = 1; k <= 118; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
         nb += int'(bus.sec_borrow);
         nd += int'(bus.done);
         if (k == 60) begin
            total++;
            if (snap() !== {8'h00, 8'h59, 3'b110}) $display("FAIL tick_0100 got %h want %h", snap(), {8'h00, 8'h59, 3'b110});
            else passed++;
         end
      end
      total++;
      if ({nb, nd, snap()} !== {32'd1, 32'd0, 8'h00, 8'h01, 3'b010})
         $display("FAIL run_to_0001 got nb=%0d nd=%0d %h want nb=1 nd=0 %h", nb, nd, snap(), {8'h00, 8'h01, 3'b010});
      else passed++;
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (snap() !== {8'h00, 8'h00, 3'b001}) $display("FAIL terminal got %h want %h", snap(), {8'h00, 8'h00, 3'b001});
      else passed++;
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (snap() !== 19'h0) $display("FAIL done_hold got %h want %h", snap(), 19'h0);
      else passed++;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (snap() !== 19'h0) $display("FAIL start_in_done got %h want %h", snap(), 19'h0);
      else passed++;
   endtask

   task automatic test_pause();
      do_load(8'h00, 8'h03);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (snap() !== {8'h00, 8'h02, 3'b000}) $display("FAIL pause_hold got %h want %h", snap(), {8'h00, 8'h02, 3'b000});
      else passed++;
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      total++;
      if (snap() !== {8'h00, 8'h02, 3'b000}) $display("FAIL start_pause_in_pause got %h want %h", snap(), {8'h00, 8'h02, 3'b000});
      else passed++;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (snap() !== {8'h00, 8'h01, 3'b010}) $display("FAIL resume got %h want %h", snap(), {8'h00, 8'h01, 3'b010});
      else passed++;
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (snap() !== {8'h00, 8'h00, 3'b001}) $display("FAIL pause_terminal got %h want %h", snap(), {8'h00, 8'h00, 3'b001});
      else passed++;
   endtask

   task automatic test_saturate();
      do_load(8'hA3, 8'h7C);
      total++;
      if (snap() !== {8'h53, 8'h59, 3'b000}) $display("FAIL saturate got %h want %h", snap(), {8'h53, 8'h59, 3'b000});
      else passed++;
   endtask

   task automatic test_coincident();
      do_load(8'h00, 8'h05);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      do_load(8'h00, 8'h30);
      total++;
      if (snap() !== {8'h00, 8'h05, 3'b010}) $display("FAIL load_in_run got %h want %h", snap(), {8'h00, 8'h05, 3'b010});
      else passed++;
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      total++;
      if (snap() !== {8'h00, 8'h05, 3'b000}) $display("FAIL tick_with_pause got %h want %h", snap(), {8'h00, 8'h05, 3'b000});
      else passed++;
      do_load(8'h00, 8'h05);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      total++;
      if (snap() !== {8'h00, 8'h05, 3'b000}) $display("FAIL start_pause_idle got %h want %h", snap(), {8'h00, 8'h05, 3'b000});
      else passed++;
      bus.preset_min = 8'h00; bus.preset_sec = 8'h07;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (snap() !== {8'h00, 8'h07, 3'b000}) $display("FAIL load_start_idle got %h want %h", snap(), {8'h00, 8'h07, 3'b000});
      else passed++;
      do_load(8'h00, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (snap() !== 19'h0) $display("FAIL start_at_zero got %h want %h", snap(), 19'h0);
      else passed++;
   endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      logic [7:0] exp_sec [4];
      logic       exp_done [4];
      exp_sec[0] = 8'h01; exp_sec[1] = 8'h02; exp_sec[2] = 8'h01; exp_sec[3] = 8'h02;
      exp_done[0] = 1'b0; exp_done[1] = 1'b1; exp_done[2] = 1'b0; exp_done[3] = 1'b1;
      do_load(8'h00, 8'h02);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
         total++;
         if (snap() !== {8'h00, exp_sec[i], 1'b0, 1'b1, exp_done[i]})
            $display("FAIL auto_reload_%0d got %h want %h", i, snap(), {8'h00, exp_sec[i], 1'b0, 1'b1, exp_done[i]});
         else passed++;
      end
   endtask
`endif

   initial begin
      bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
      bus.preset_min = 8'h00; bus.preset_sec = 8'h00;
      test_reset();
      test_reset_mid();
      test_borrow_and_done();
      test_pause();
      test_saturate();
      test_coincident();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      test_auto_reload();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
